// File: rtl/data_bus_pkg.sv
// rtl/data_bus_pkg.sv - address map, register offsets and status layout for the CPU data-port responder
package data_bus_pkg;

    // RAM window: 4 KiB at the bottom of the address space
    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] RAM_LIMIT = 32'h0000_0FFF;

    // Memory-mapped I/O block
    localparam logic [31:0] IO_BASE       = 32'h8000_0000;
    localparam logic [31:0] GPIO_OFS      = 32'h0000_0000;
    localparam logic [31:0] CYCLE_OFS     = 32'h0000_0004;
    localparam logic [31:0] CONS_TX_OFS   = 32'h0000_0008;
    localparam logic [31:0] CONS_STAT_OFS = 32'h0000_000C;

    // CONS_STAT bit positions
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_GPIO,
        SEL_CYCLE,
        SEL_CONS_TX,
        SEL_CONS_STAT
    } sel_e;

    // Word-granular decode; the two byte-offset bits never affect the target
    function automatic sel_e decode_addr(input logic [31:0] addr);
        logic [31:0] word_addr;
        word_addr = addr & 32'hFFFF_FFFC;
        if ((word_addr & ~RAM_LIMIT) == RAM_BASE) begin
            return SEL_RAM;
        end else if (word_addr == IO_BASE + GPIO_OFS) begin
            return SEL_GPIO;
        end else if (word_addr == IO_BASE + CYCLE_OFS) begin
            return SEL_CYCLE;
        end else if (word_addr == IO_BASE + CONS_TX_OFS) begin
            return SEL_CONS_TX;
        end else if (word_addr == IO_BASE + CONS_STAT_OFS) begin
            return SEL_CONS_STAT;
        end
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// rtl/console_fifo.sv - byte-wide circular FIFO feeding the console valid/ready sink
module console_fifo
    import data_bus_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     push,
    input  logic [7:0]               pushData,
    output logic                     pushOk,
    output logic                     popValid,
    output logic [7:0]               popData,
    input  logic                     popReady,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop;

    // Flag/handshake decode and next-state pointers; a push into a full FIFO
    // is still taken when the head leaves in the same cycle
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_CNT);
        popValid = !empty;
        pop      = popValid && popReady;
        pushOk   = push && (!full || pop);
        rd_ptr_d = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = pushOk ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        case ({pushOk, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state; reset empties the FIFO without touching storage
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Byte storage; when full with a pop, the slot written is the one being vacated
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wr_ptr_q] <= pushData;
        end
    end

    assign popData = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - single-cycle data-port responder: RAM, GPIO, cycle counter, console FIFO
module data_bus_responder
    import data_bus_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    input  logic        we,
    output logic [31:0] readData,
    output logic [31:0] gpioOut,
    output logic [7:0]  consData,
    output logic        consValid,
    input  logic        consReady
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    sel_e              sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_ram, wr_gpio, wr_cycle, wr_tx, wr_stat;

    logic [31:0]       ram_mem [RAM_WORDS];

    logic [31:0]       gpio_q, gpio_d;
    logic [31:0]       cycle_q, cycle_d;
    logic              ovf_q, ovf_d;

    logic              push_ok;
    logic              push_drop;
    logic [CNT_W-1:0]  cons_count;
    logic              cons_full, cons_empty;
    logic [31:0]       stat_word;

    // Address decode and per-target write strobes
    always_comb begin
        sel      = decode_addr(dataAddr);
        ram_idx  = dataAddr[2 +: RAM_AW];
        wr_ram   = we && (sel == SEL_RAM);
        wr_gpio  = we && (sel == SEL_GPIO);
        wr_cycle = we && (sel == SEL_CYCLE);
        wr_tx    = we && (sel == SEL_CONS_TX);
        wr_stat  = we && (sel == SEL_CONS_STAT);
    end

    // Word RAM: write-only clocked port, no reset so contents survive n_reset
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram_mem[ram_idx] <= writeData;
        end
    end

    console_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk      (clk),
        .n_reset  (n_reset),
        .push     (wr_tx),
        .pushData (writeData[7:0]),
        .pushOk   (push_ok),
        .popValid (consValid),
        .popData  (consData),
        .popReady (consReady),
        .count    (cons_count),
        .full     (cons_full),
        .empty    (cons_empty)
    );

    assign push_drop = wr_tx && !push_ok;

    // Next-state for GPIO, the free-running counter and the sticky overflow flag;
    // a dropped push wins over a same-cycle clear so no loss goes unreported
    always_comb begin
        gpio_d  = wr_gpio  ? writeData : gpio_q;
        cycle_d = wr_cycle ? writeData : cycle_q + 32'd1;
        ovf_d   = ovf_q;
        if (wr_stat && writeData[STAT_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
        if (push_drop) begin
            ovf_d = 1'b1;
        end
    end

    // Register state with asynchronous clear
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            gpio_q  <= '0;
            cycle_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            gpio_q  <= gpio_d;
            cycle_q <= cycle_d;
            ovf_q   <= ovf_d;
        end
    end

    // Console status word; count is zero-extended into its 8-bit field
    always_comb begin
        stat_word                             = '0;
        stat_word[STAT_EMPTY_BIT]             = cons_empty;
        stat_word[STAT_FULL_BIT]              = cons_full;
        stat_word[STAT_OVF_BIT]               = ovf_q;
        stat_word[STAT_COUNT_LSB +: CNT_W]    = cons_count;
    end

    // Load mux: purely combinational, shows pre-write state during a store
    always_comb begin
        readData = '0;
        case (sel)
            SEL_RAM:       readData = ram_mem[ram_idx];
            SEL_GPIO:      readData = gpio_q;
            SEL_CYCLE:     readData = cycle_q;
            SEL_CONS_STAT: readData = stat_word;
            default:       readData = '0;
        endcase
    end

    assign gpioOut = gpio_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - self-checking bench for data_bus_responder
module tb_data_bus_responder;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] A_GPIO = 32'h8000_0000;
    localparam logic [31:0] A_CYC  = 32'h8000_0004;
    localparam logic [31:0] A_TX   = 32'h8000_0008;
    localparam logic [31:0] A_STAT = 32'h8000_000C;

    logic        clk       = 1'b0;
    logic        n_reset   = 1'b0;
    logic [31:0] dataAddr  = '0;
    logic [31:0] writeData = '0;
    logic        we        = 1'b0;
    logic        consReady = 1'b0;
    logic [31:0] readData;
    logic [31:0] gpioOut;
    logic [7:0]  consData;
    logic        consValid;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_ram [int];
    logic [31:0] m_gpio;
    logic [31:0] m_cycle;
    logic        m_ovf;
    logic [7:0]  m_q [$];

    always #5 clk = ~clk;

    data_bus_responder #(
        .RAM_WORDS  (1024),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .dataAddr  (dataAddr),
        .writeData (writeData),
        .we        (we),
        .readData  (readData),
        .gpioOut   (gpioOut),
        .consData  (consData),
        .consValid (consValid),
        .consReady (consReady)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        dataAddr  = a;
        writeData = d;
        we        = 1'b1;
        tick();
        we        = 1'b0;
    endtask

    function automatic logic [31:0] model_stat();
        return {16'h0, 8'(m_q.size()), 5'h0, m_ovf,
                (m_q.size() == DEPTH), (m_q.size() == 0)};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w < 32'h0000_1000) return m_ram[int'(w >> 2)];
        if (w == A_GPIO)       return m_gpio;
        if (w == A_CYC)        return m_cycle;
        if (w == A_STAT)       return model_stat();
        return 32'h0;
    endfunction

    task automatic test_reset();
        n_reset   = 1'b0;
        consReady = 1'b0;
        dataAddr  = A_STAT;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (gpioOut !== 32'h0) begin errors++; $display("FAIL reset_gpio: got %h want %h", gpioOut, 32'h0); end
        checks++; if (consValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", consValid); end
        checks++; if (readData !== 32'h1) begin errors++; $display("FAIL reset_stat: got %h want %h", readData, 32'h1); end
        dataAddr = A_CYC;
        #1;
        checks++; if (readData !== 32'h0) begin errors++; $display("FAIL reset_cycle: got %h want 0", readData); end
        n_reset = 1'b1;
        #1;
        checks++; if (readData !== 32'h0) begin errors++; $display("FAIL cycle_0: got %h want 0", readData); end
        tick();
        checks++; if (readData !== 32'h1) begin errors++; $display("FAIL cycle_1: got %h want 1", readData); end
        tick();
        checks++; if (readData !== 32'h2) begin errors++; $display("FAIL cycle_2: got %h want 2", readData); end
    endtask

    task automatic test_ram();
        store(32'h0000_0010, 32'h1234_5678);
        dataAddr  = 32'h0000_0010;
        writeData = 32'hDEAD_BEEF;
        we        = 1'b1;
        #1;
        checks++; if (readData !== 32'h1234_5678) begin errors++; $display("FAIL ram_prewrite: got %h want %h", readData, 32'h1234_5678); end
        tick();
        we = 1'b0;
        checks++; if (readData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_10: got %h want %h", readData, 32'hDEAD_BEEF); end
        dataAddr = 32'h0000_0013;
        #1;
        checks++; if (readData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_13: got %h want %h", readData, 32'hDEAD_BEEF); end
        dataAddr = 32'h4000_0000;
        #1;
        checks++; if (readData !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", readData); end
    endtask

    task automatic test_gpio_cycle();
        dataAddr  = A_GPIO;
        writeData = 32'h0000_00A5;
        we        = 1'b1;
        #1;
        checks++; if (gpioOut !== 32'h0) begin errors++; $display("FAIL gpio_pre: got %h want 0", gpioOut); end
        tick();
        we = 1'b0;
        checks++; if (gpioOut !== 32'hA5) begin errors++; $display("FAIL gpio_out: got %h want %h", gpioOut, 32'hA5); end
        checks++; if (readData !== 32'hA5) begin errors++; $display("FAIL gpio_read: got %h want %h", readData, 32'hA5); end
        store(A_CYC, 32'hFFFF_FFFE);
        checks++; if (readData !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cycle_load: got %h want %h", readData, 32'hFFFF_FFFE); end
        tick();
        checks++; if (readData !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_max: got %h want %h", readData, 32'hFFFF_FFFF); end
        tick();
        checks++; if (readData !== 32'h0) begin errors++; $display("FAIL cycle_wrap: got %h want 0", readData); end
    endtask

    task automatic test_fifo_overflow();
        consReady = 1'b0;
        for (int i = 0; i < 9; i++) store(A_TX, 32'h41 + 32'(i));
        dataAddr = A_STAT;
        #1;
        checks++; if (readData !== 32'h0000_0806) begin errors++; $display("FAIL ovf_stat: got %h want %h", readData, 32'h806); end
        consReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (consValid !== 1'b1 || consData !== 8'(8'h41 + i)) begin
                errors++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, consValid, consData, 8'(8'h41 + i));
            end
            tick();
        end
        consReady = 1'b0;
        #1;
        checks++; if (consValid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", consValid); end
        checks++; if (readData !== 32'h0000_0005) begin errors++; $display("FAIL empty_ovf_stat: got %h want %h", readData, 32'h5); end
        store(A_STAT, 32'h4);
        checks++; if (readData !== 32'h0000_0001) begin errors++; $display("FAIL ovf_clear: got %h want %h", readData, 32'h1); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        consReady = 1'b0;
        for (int i = 0; i < 8; i++) store(A_TX, 32'h41 + 32'(i));
        dataAddr = A_STAT;
        #1;
        checks++; if (readData !== 32'h0000_0802) begin errors++; $display("FAIL full_stat: got %h want %h", readData, 32'h802); end
        dataAddr  = A_TX;
        writeData = 32'h5A;
        we        = 1'b1;
        consReady = 1'b1;
        #1;
        checks++; if (consData !== 8'h41) begin errors++; $display("FAIL full_head: got %h want 41", consData); end
        tick();
        we        = 1'b0;
        consReady = 1'b0;
        dataAddr  = A_STAT;
        #1;
        checks++; if (readData !== 32'h0000_0802) begin errors++; $display("FAIL pushpop_stat: got %h want %h", readData, 32'h802); end
        checks++; if (consData !== 8'h42) begin errors++; $display("FAIL pushpop_head: got %h want 42", consData); end
        consReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 8'(8'h42 + i) : 8'h5A;
            checks++; if (consValid !== 1'b1 || consData !== exp) begin
                errors++; $display("FAIL pp_drain_%0d: got v=%b d=%h want v=1 d=%h", i, consValid, consData, exp);
            end
            tick();
        end
        consReady = 1'b0;
        #1;
        checks++; if (consValid !== 1'b0) begin errors++; $display("FAIL pp_empty: got %b want 0", consValid); end
    endtask

    task automatic test_async_reset();
        store(32'h0000_0020, 32'hCAFE_F00D);
        store(A_GPIO, 32'h1);
        for (int i = 0; i < 3; i++) store(A_TX, 32'h61 + 32'(i));
        #1;
        checks++; if (consValid !== 1'b1 || gpioOut !== 32'h1) begin
            errors++; $display("FAIL pre_reset: got v=%b gpio=%h want v=1 gpio=1", consValid, gpioOut);
        end
        #2;
        n_reset = 1'b0;
        #1;
        checks++; if (consValid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", consValid); end
        checks++; if (gpioOut !== 32'h0) begin errors++; $display("FAIL areset_gpio: got %h want 0", gpioOut); end
        #3;
        n_reset  = 1'b1;
        dataAddr = 32'h0000_0020;
        #1;
        checks++; if (readData !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_persist_20: got %h want %h", readData, 32'hCAFE_F00D); end
        dataAddr = 32'h0000_0010;
        #1;
        checks++; if (readData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_persist_10: got %h want %h", readData, 32'hDEAD_BEEF); end
        dataAddr = A_STAT;
        #1;
        checks++; if (readData !== 32'h1) begin errors++; $display("FAIL areset_stat: got %h want 1", readData); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] a, d, w_addr, v;
        logic        w, pop;
        int          op, idx, sz;
        m_gpio = 32'h0;
        m_ovf  = 1'b0;
        m_q.delete();
        m_ram.delete();
        m_ram[4] = 32'hDEAD_BEEF;
        m_ram[8] = 32'hCAFE_F00D;
        v = $urandom;
        store(A_CYC, v);
        m_cycle = v;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            d  = $urandom;
            w  = 1'b0;
            case (op)
                0: begin a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3)); w = 1'b1; end
                1: begin
                    idx = $urandom_range(0, 63);
                    a   = m_ram.exists(idx) ? 32'(idx) * 4 + 32'($urandom_range(0, 3)) : A_GPIO;
                end
                2: begin a = A_GPIO; w = 1'b1; end
                3: begin a = A_CYC; w = ($urandom_range(0, 3) == 0); end
                4, 5: begin a = A_TX; w = 1'b1; end
                6: begin a = A_STAT; w = 1'b1; end
                7: a = A_CYC;
                8: a = A_STAT;
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = A_TX;
                        1: a = 32'h8000_0010;
                        2: a = 32'h9000_0000 | ($urandom & 32'h0FFF_FFFF);
                        default: a = 32'h0000_1000 + ($urandom & 32'h0FFF_FFFF);
                    endcase
                    w = (a != A_TX) && ($urandom_range(0, 1) == 1);
                end
            endcase
            if (((i / 40) % 2) == 1) consReady = ($urandom_range(0, 3) != 0);
            else                     consReady = ($urandom_range(0, 7) == 0);
            dataAddr  = a;
            writeData = d;
            we        = w;
            #1;
            checks++; if (readData !== model_read(a)) begin
                errors++; $display("FAIL rnd_read[%0d] addr=%h: got %h want %h", i, a, readData, model_read(a));
            end
            checks++; if (gpioOut !== m_gpio) begin
                errors++; $display("FAIL rnd_gpio[%0d]: got %h want %h", i, gpioOut, m_gpio);
            end
            checks++; if (consValid !== (m_q.size() != 0)) begin
                errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, consValid, (m_q.size() != 0));
            end
            if (m_q.size() != 0) begin
                checks++; if (consData !== m_q[0]) begin
                    errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, consData, m_q[0]);
                end
            end
            tick();
            we = 1'b0;
            w_addr = a & 32'hFFFF_FFFC;
            sz  = m_q.size();
            pop = (sz != 0) && consReady;
            if (pop) void'(m_q.pop_front());
            if (w && w_addr == A_STAT && d[2]) m_ovf = 1'b0;
            if (w && w_addr == A_TX) begin
                if (sz < DEPTH || pop) m_q.push_back(d[7:0]);
                else                   m_ovf = 1'b1;
            end
            m_cycle = (w && w_addr == A_CYC) ? d : m_cycle + 32'd1;
            if (w && w_addr == A_GPIO) m_gpio = d;
            if (w && w_addr < 32'h0000_1000) m_ram[int'(w_addr >> 2)] = d;
        end
        consReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_gpio_cycle();
        test_fifo_overflow();
        test_full_push_pop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
